// File: rtl/seq_alu.sv
// Sequential RV32-style ALU: single-cycle base ops, iterative shift-add multiply and restoring divide.
// Build option: define SEQ_ALU_MEXT_EN to include the MUL/DIV datapath; otherwise mext requests complete with err.
module seq_alu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic [2:0]      funct3,
    input  logic            alt,
    input  logic            mext,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] Result,
    output logic            zero,
    output logic            err
);
    localparam int SHW = $clog2(XLEN);

`ifdef SEQ_ALU_MEXT_EN
    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, DONE = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd3} state_t;
`endif

    state_t state;

    function automatic logic [XLEN-1:0] base_op(
        input logic [XLEN-1:0] a,
        input logic [XLEN-1:0] b,
        input logic [2:0]      f,
        input logic            sel_alt
    );
        logic signed [XLEN-1:0] as_v;
        logic signed [XLEN-1:0] bs_v;
        logic [SHW-1:0]         sh;
        logic [XLEN-1:0]        r;
        as_v = a;
        bs_v = b;
        sh   = b[SHW-1:0];
        case (f)
            3'b000:  r = sel_alt ? a - b : a + b;
            3'b001:  r = a << sh;
            3'b010:  r = {{(XLEN-1){1'b0}}, (as_v < bs_v)};
            3'b011:  r = {{(XLEN-1){1'b0}}, (a < b)};
            3'b100:  r = a ^ b;
            3'b101:  r = sel_alt ? XLEN'(as_v >>> sh) : a >> sh;
            3'b110:  r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign zero      = (Result == '0);

`ifdef SEQ_ALU_MEXT_EN
    localparam logic [SHW-1:0] LAST = SHW'(XLEN - 1);

    function automatic logic [XLEN-1:0] neg_if(input logic n, input logic [XLEN-1:0] v);
        return n ? -v : v;
    endfunction

    function automatic logic [2*XLEN-1:0] neg2_if(input logic n, input logic [2*XLEN-1:0] v);
        return n ? -v : v;
    endfunction

    logic [SHW-1:0]     cnt;
    logic [1:0]         op_lo;
    logic               neg_res;
    logic               neg_rem;
    logic [2*XLEN-1:0]  prod;
    logic [XLEN-1:0]    mcand;
    logic [XLEN-1:0]    quot;
    logic [XLEN-1:0]    rem;
    logic [XLEN-1:0]    dvsr;

    logic               a_sgn, b_sgn, a_neg, b_neg;
    logic [XLEN-1:0]    a_mag, b_mag;
    logic               div_zero, div_ovf;
    logic [XLEN-1:0]    bypass_res;

    logic [XLEN:0]      mul_sum;
    logic [2*XLEN-1:0]  prod_nxt, prod_fin;
    logic [XLEN:0]      div_shift;
    logic               div_ge;
    logic [XLEN-1:0]    rem_nxt, quot_nxt, q_fin, r_fin;

    // Operand signedness and divide bypass decode, evaluated on the accept cycle.
    always_comb begin
        a_sgn = 1'b0;
        b_sgn = 1'b0;
        case (funct3)
            3'b001:         begin a_sgn = 1'b1; b_sgn = 1'b1; end
            3'b010:         a_sgn = 1'b1;
            3'b100, 3'b110: begin a_sgn = 1'b1; b_sgn = 1'b1; end
            default:        ;
        endcase
        a_neg      = a_sgn & A[XLEN-1];
        b_neg      = b_sgn & B[XLEN-1];
        a_mag      = neg_if(a_neg, A);
        b_mag      = neg_if(b_neg, B);
        div_zero   = (B == '0);
        div_ovf    = !funct3[0] && (A == {1'b1, {(XLEN-1){1'b0}}}) && (&B);
        if (div_zero)
            bypass_res = funct3[1] ? A : '1;
        else
            bypass_res = funct3[1] ? '0 : A;
    end

    always_comb begin
        mul_sum   = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, mcand} : '0);
        prod_nxt  = {mul_sum, prod[XLEN-1:1]};
        prod_fin  = neg2_if(neg_res, prod_nxt);
        div_shift = {rem, quot[XLEN-1]};
        div_ge    = (div_shift >= {1'b0, dvsr});
        rem_nxt   = div_ge ? XLEN'(div_shift - {1'b0, dvsr}) : div_shift[XLEN-1:0];
        quot_nxt  = {quot[XLEN-2:0], div_ge};
        q_fin     = neg_if(neg_res, quot_nxt);
        r_fin     = neg_if(neg_rem, rem_nxt);
    end

    // Iteration registers carry no reset; they are always reloaded on accept.
    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid && mext) begin
            op_lo   <= funct3[1:0];
            neg_res <= a_neg ^ b_neg;
            neg_rem <= a_neg;
            prod    <= {{XLEN{1'b0}}, b_mag};
            mcand   <= a_mag;
            quot    <= a_mag;
            rem     <= '0;
            dvsr    <= b_mag;
        end else if (state == MUL) begin
            prod <= prod_nxt;
        end else if (state == DIV) begin
            quot <= quot_nxt;
            rem  <= rem_nxt;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            Result <= '0;
            err    <= 1'b0;
`ifdef SEQ_ALU_MEXT_EN
            cnt    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (!mext) begin
                            Result <= base_op(A, B, funct3, alt);
                            err    <= 1'b0;
                            state  <= DONE;
                        end
`ifdef SEQ_ALU_MEXT_EN
                        else if (!funct3[2]) begin
                            cnt   <= '0;
                            state <= MUL;
                        end else if (div_zero || div_ovf) begin
                            Result <= bypass_res;
                            err    <= 1'b0;
                            state  <= DONE;
                        end else begin
                            cnt   <= '0;
                            state <= DIV;
                        end
`else
                        else begin
                            Result <= '0;
                            err    <= 1'b1;
                            state  <= DONE;
                        end
`endif
                    end
                end
`ifdef SEQ_ALU_MEXT_EN
                // Final iteration folds sign correction and result select into the same edge.
                MUL: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        Result <= (op_lo == 2'b00) ? prod_fin[XLEN-1:0] : prod_fin[2*XLEN-1:XLEN];
                        err    <= 1'b0;
                        state  <= DONE;
                    end
                end
                DIV: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        Result <= op_lo[1] ? r_fin : q_fin;
                        err    <= 1'b0;
                        state  <= DONE;
                    end
                end
`endif
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu (XLEN=32): directed cases, reset/stall cases, then randomized traffic.
// Expected values follow SEQ_ALU_MEXT_EN the same way the design does.
module tb_seq_alu;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  funct3;
    logic        alt;
    logic        mext;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Result;
    logic        zero;
    logic        err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rdy_mode = 0;

    typedef struct {
        logic [31:0] r;
        logic        e;
        int          vis;
    } exp_t;
    exp_t sbq[$];

    seq_alu #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .funct3(funct3), .alt(alt), .mext(mext),
        .out_valid(out_valid), .out_ready(out_ready),
        .Result(Result), .zero(zero), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // Reference: operations straight from the ISA definitions using wide integer arithmetic.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f,
                                  input logic al, input logic m,
                                  output logic [31:0] r, output logic e, output int lat);
        int sa, sb;
        longint pa, pb;
        longint unsigned ua, ub;
        bit ovf;
        sa = a; sb = b;
        pa = longint'(sa); pb = longint'(sb);
        ua = {32'b0, a}; ub = {32'b0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        e = 1'b0; lat = 1; r = '0;
        if (!m) begin
            case (f)
                3'd0: r = al ? a - b : a + b;
                3'd1: r = a << b[4:0];
                3'd2: r = (sa < sb) ? 32'd1 : 32'd0;
                3'd3: r = (a < b) ? 32'd1 : 32'd0;
                3'd4: r = a ^ b;
                3'd5: r = al ? 32'(sa >>> b[4:0]) : a >> b[4:0];
                3'd6: r = a | b;
                default: r = a & b;
            endcase
        end else begin
`ifdef SEQ_ALU_MEXT_EN
            case (f)
                3'd0: r = 32'(pa * pb);
                3'd1: r = 32'((pa * pb) >>> 32);
                3'd2: r = 32'((pa * longint'(ub)) >>> 32);
                3'd3: r = 32'((ua * ub) >> 32);
                3'd4: r = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
                3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
                3'd6: r = (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
                default: r = (b == 0) ? a : a % b;
            endcase
            if (f >= 3'd4 && (b == 0 || (ovf && (f == 3'd4 || f == 3'd6))))
                lat = 1;
            else
                lat = 33;
`else
            r = '0; e = 1'b1; lat = 1;
`endif
        end
    endfunction

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f,
                        input logic al, input logic m, input logic [31:0] er, input logic ee,
                        input int lat, output int acc);
        exp_t it;
        bit done;
        A = a; B = b; funct3 = f; alt = al; mext = m; in_valid = 1'b1;
        done = 0; acc = -1;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                it.r = er; it.e = ee; it.vis = cyc + lat;
                sbq.push_back(it);
                acc = cyc + 1;
                done = 1;
            end
        end
        if (!done) chk("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        A = $urandom(); B = $urandom(); funct3 = 3'($urandom_range(0, 7)); mext = 1'($urandom_range(0, 1));
    endtask

    task automatic send_rand();
        logic [31:0] a, b, er;
        logic [2:0] f;
        logic al, m, ee;
        int lat, acc;
        a = rnd_op(); b = rnd_op();
        f = 3'($urandom_range(0, 7));
        al = 1'($urandom_range(0, 1));
        m = 1'($urandom_range(0, 1));
        model(a, b, f, al, m, er, ee, lat);
        send(a, b, f, al, m, er, ee, lat, acc);
    endtask

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 15));
            4: return -32'($urandom_range(1, 15));
            default: return $urandom();
        endcase
    endfunction

    task automatic set_mode(input int md);
        rdy_mode = md;
        @(posedge clk);
        #2;
    endtask

    task automatic drain();
        bit done;
        done = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (sbq.size() == 0) done = 1;
        end
        if (!done) chk("drain_timeout", 64'(sbq.size()), 64'd0);
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: out_ready = 1'b1;
                1: out_ready = ($urandom_range(0, 2) != 0);
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops the scoreboard on each handshake, checks latency and hold stability.
    initial begin
        bit seen, held;
        logic [31:0] held_r;
        exp_t it;
        seen = 0; held = 0; held_r = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                seen = 0; held = 0;
            end else if (out_valid) begin
                chk("in_ready_while_done", 64'(in_ready), 64'd0);
                if (held) chk("hold_stable", 64'(Result), 64'(held_r));
                if (sbq.size() == 0) begin
                    chk("spurious_valid", 64'd1, 64'd0);
                end else begin
                    it = sbq[0];
                    if (!seen) begin
                        chk("latency_cycle", 64'(cyc), 64'(it.vis));
                        seen = 1;
                    end
                    if (out_ready) begin
                        chk("result", 64'(Result), 64'(it.r));
                        chk("err", 64'(err), 64'(it.e));
                        chk("zero", 64'(zero), 64'(it.r == 0));
                        void'(sbq.pop_front());
                        seen = 0; held = 0;
                    end else begin
                        held = 1; held_r = Result;
                    end
                end
            end else begin
                held = 0;
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, rel;
        rst_n = 1'b1; in_valid = 1'b0; A = '0; B = '0; funct3 = '0; alt = 1'b0; mext = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_result", 64'(Result), 64'd0);
        chk("rst_zero", 64'(zero), 64'd1);
        chk("rst_err", 64'(err), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        send(32'd5, 32'd7, 3'd0, 1'b0, 1'b0, 32'd12, 1'b0, 1, acc);
        send(32'd7, 32'd7, 3'd0, 1'b1, 1'b0, 32'd0, 1'b0, 1, acc);
        send(32'h8000_0000, 32'd33, 3'd5, 1'b1, 1'b0, 32'hC000_0000, 1'b0, 1, acc);
        send(32'd1, 32'hFFFF_FFFF, 3'd3, 1'b0, 1'b0, 32'd1, 1'b0, 1, acc);
        send(32'd1, 32'hFFFF_FFFF, 3'd2, 1'b0, 1'b0, 32'd0, 1'b0, 1, acc);
`ifdef SEQ_ALU_MEXT_EN
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd3, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 33, acc);
        send(-32'd7, 32'd3, 3'd0, 1'b0, 1'b1, 32'hFFFF_FFEB, 1'b0, 33, acc);
        send(-32'd7, 32'd2, 3'd4, 1'b0, 1'b1, 32'hFFFF_FFFD, 1'b0, 33, acc);
        send(-32'd7, 32'd2, 3'd6, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 33, acc);
        send(32'd5, 32'd0, 3'd5, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1, acc);
        send(32'd5, 32'd0, 3'd7, 1'b0, 1'b1, 32'd5, 1'b0, 1, acc);
        send(32'h8000_0000, 32'hFFFF_FFFF, 3'd4, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 1, acc);
        send(32'h8000_0000, 32'hFFFF_FFFF, 3'd6, 1'b0, 1'b1, 32'd0, 1'b0, 1, acc);
        send(32'd3, 32'd4, 3'd0, 1'b0, 1'b1, 32'd12, 1'b0, 33, acc);
`else
        send(32'd3, 32'd4, 3'd0, 1'b0, 1'b1, 32'd0, 1'b1, 1, acc);
`endif
        send(32'd1, 32'd1, 3'd0, 1'b0, 1'b0, 32'd2, 1'b0, 1, acc);
        drain();

        set_mode(2);
        send(32'd5, 32'd7, 3'd0, 1'b0, 1'b0, 32'd12, 1'b0, 1, acc);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid", 64'(out_valid), 64'd1);
            chk("stall_result", 64'(Result), 64'd12);
            chk("stall_in_ready", 64'(in_ready), 64'd0);
        end
        set_mode(0);
        drain();

        set_mode(2);
`ifdef SEQ_ALU_MEXT_EN
        send(-32'd7, 32'd2, 3'd4, 1'b0, 1'b1, 32'hFFFF_FFFD, 1'b0, 33, acc);
`else
        send(-32'd7, 32'd2, 3'd4, 1'b0, 1'b1, 32'd0, 1'b1, 1, acc);
`endif
        repeat (9) @(posedge clk);
        #1 rst_n = 1'b0;
        sbq.delete();
        #1;
        chk("midop_rst_out_valid", 64'(out_valid), 64'd0);
        chk("midop_rst_in_ready", 64'(in_ready), 64'd1);
        chk("midop_rst_result", 64'(Result), 64'd0);
        chk("midop_rst_zero", 64'(zero), 64'd1);
        rdy_mode = 0;
        repeat (2) begin
            @(negedge clk);
            chk("held_rst_out_valid", 64'(out_valid), 64'd0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        rel = cyc;
        send(32'd1, 32'd2, 3'd0, 1'b0, 1'b0, 32'd3, 1'b0, 1, acc);
        chk("first_accept_after_reset", 64'(acc), 64'(rel + 1));
        repeat (40) @(negedge clk);
        drain();

        set_mode(1);
        for (int i = 0; i < 300; i++) send_rand();
        set_mode(0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the operand/result width; legal values are 8..64, powers of two.
REQ-002 clk  input  1  sole clock, rising-edge active.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  request present.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 A  input  XLEN  operand rs1.
REQ-007 B  input  XLEN  operand rs2 or immediate.
REQ-008 funct3  input  3  operation select.
REQ-009 alt  input  1  funct7[5]; selects SUB/SRA.
REQ-010 mext  input  1  1 = M-extension operation.
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  consumer takes result.
REQ-013 Result  output  XLEN  registered result.
REQ-014 zero  output  1  Result == 0.
REQ-015 err  output  1  unsupported operation completed.

Function
REQ-016 Transfers SHALL occur only on cycles where valid and ready are both high at a clk edge; operands are captured at accept.
REQ-017 FSM states SHALL be IDLE, MUL, DIV, DONE; in_ready = (state == IDLE).
REQ-018 Base ops (mext=0) SHALL use funct3: 000 ADD/SUB(alt), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA(alt), 110 OR, 111 AND.
REQ-019 Shift amount SHALL be B[log2(XLEN)-1:0]; SLT/SLTU yield 1 or 0 zero-extended.
REQ-020 Base ops SHALL go IDLE->DONE; out_valid is high the cycle after accept (latency 1).
REQ-021 M ops (mext=1) SHALL use funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-022 MUL* SHALL run an iterative shift-add over a 2*XLEN product for exactly XLEN cycles in MUL, then DONE; latency XLEN+1.
REQ-023 DIV* SHALL run an iterative restoring divide on magnitudes for exactly XLEN cycles in DIV, then sign-correct and go to DONE; latency XLEN+1.
REQ-024 Divide by zero SHALL bypass DIV: quotient all-ones, remainder = A, latency 1.
REQ-025 Signed overflow (A = most-negative, B = -1) SHALL bypass DIV: DIV result = A, REM result = 0, latency 1.
REQ-026 Remainder sign SHALL follow dividend; quotient truncates toward zero.
REQ-027 In DONE, Result/zero/err SHALL hold stable until out_ready; DONE->IDLE on out_valid && out_ready.
REQ-028 A new request SHALL NOT be accepted in the same cycle as a result handoff (no bypass); next accept is one cycle later.
REQ-029 in_valid, operands and op inputs SHALL be ignored outside IDLE.
REQ-030 zero SHALL be computed from the registered Result; err SHALL be 0 for all supported operations.

Reset
REQ-031 rst_n low SHALL immediately force state IDLE, out_valid 0, Result 0, zero 1, err 0, in_ready 1, and clear the iteration counter.
REQ-032 Reset mid-MUL/DIV SHALL discard the operation; no result is ever presented for it.
REQ-033 First accept after reset release SHALL be possible on the first clk edge with rst_n high.

Configuration
REQ-034 With macro SEQ_ALU_MEXT_EN defined, the MUL/DIV states and datapath SHALL be compiled in per REQ-021..026.
REQ-035 Without SEQ_ALU_MEXT_EN, any mext=1 request SHALL complete with latency 1, Result 0, zero 1, err 1; MUL/DIV states SHALL be absent; base-op behaviour is unchanged.

Verification (XLEN=32)
REQ-036 ADD 5+7 -> Result 12, zero 0, out_valid 1 cycle after accept; SUB 7-7 -> Result 0, zero 1.
REQ-037 SRA A=0x80000000 B=33 -> 0xC0000000; SLTU 1 vs 0xFFFFFFFF -> 1; SLT same operands -> 0.
REQ-038 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE, out_valid exactly 33 cycles after accept; MUL -7 x 3 -> 0xFFFFFFEB.
REQ-039 DIV -7/2 -> 0xFFFFFFFD, REM -> 0xFFFFFFFF; DIVU 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, both latency 1; DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
REQ-040 out_ready held low 5 cycles in DONE -> Result stable, in_ready 0 throughout; rst_n pulsed low at cycle 10 of a DIV -> out_valid 0, in_ready 1 immediately, no stale result afterwards.
REQ-041 Macro undefined: MUL 3x4 -> Result 0, err 1, zero 1, latency 1; following ADD 1+1 -> 2, err 0.
